dcache_line_writer: RTL
=======================

// Module: dcache_line_writer
// PURPOSE
//   AXI4 write-channel initiator for the memory stage: the write-side counterpart of the data-side AXI read path.
//   Accepts one cache line (e.g. dirty-line eviction or store flush) and emits one INCR burst on AW/W.
//   Collects the B response and reports completion to the memory stage.
//   One request in flight; sits between the data cache and the top-level m_axi_aw*/w*/b* ports.
// PARAMETERS
//   ADDR_WIDTH   64  byte address width
//   DATA_WIDTH   64  AXI data bus width (bits); beat = DATA_WIDTH/8 bytes
//   LINE_WORDS   8   beats per line; line = LINE_WORDS*DATA_WIDTH/8 bytes (64 B default)
// PORTS
//   clk            in   1                      clock, all logic on rising edge
//   reset          in   1                      synchronous, active-high
//   req_valid      in   1                      line write request
//   req_ready      out  1                      block can accept a request (IDLE)
//   req_addr       in   ADDR_WIDTH             any byte address inside target line
//   req_line       in   LINE_WORDS*DATA_WIDTH  line data; word i = bits [i*DATA_WIDTH +: DATA_WIDTH]
//   write_done     out  1                      1-cycle pulse: burst acknowledged
//   write_err      out  1                      valid with write_done: bresp[1] was set
//   m_axi_awvalid  out  1                      write address valid
//   m_axi_awready  in   1                      write address ready
//   m_axi_awaddr   out  ADDR_WIDTH             line-aligned burst address
//   m_axi_awlen    out  8                      LINE_WORDS-1
//   m_axi_awsize   out  3                      log2(DATA_WIDTH/8) (3 for 64-bit)
//   m_axi_awburst  out  2                      2'b01 INCR
//   m_axi_wvalid   out  1                      write data valid
//   m_axi_wready   in   1                      write data ready
//   m_axi_wdata    out  DATA_WIDTH             current beat data
//   m_axi_wstrb    out  DATA_WIDTH/8           all ones
//   m_axi_wlast    out  1                      final beat of burst
//   m_axi_bvalid   in   1                      write response valid
//   m_axi_bready   out  1                      ready for write response
//   m_axi_bresp    in   2                      write response code
// BEHAVIOUR
//   Interface: single clock clk; reset is synchronous and active-high.
//   FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE.
//   IDLE: req_ready=1.
//     - On req_valid: latch req_line and awaddr = req_addr with low log2(line bytes) bits cleared; go ADDR.
//   ADDR: awvalid=1; awaddr/awlen/awsize/awburst held stable until awready.
//     - awvalid&awready: awvalid->0, beat=0, go DATA. W is never driven before the AW handshake.
//   DATA: wvalid=1, wdata=word[beat], wlast=(beat==LINE_WORDS-1).
//     - wready=0: wdata and wlast held stable, wvalid stays 1.
//     - wready=1: beat++; on the last beat, wvalid->0 and go RESP.
//     - wvalid never drops between beats.
//   RESP: bready=1.
//     - bvalid: next cycle write_done=1, write_err=bresp[1], state=IDLE.
//     - No retry on error.
//   req_ready = (state==IDLE) & ~reset. A request may be accepted in the same cycle write_done is high.
//   req_valid outside IDLE is ignored (not queued).
//   Latency with an always-ready slave: accept at cycle 0, awvalid at 1, W beats at 2..LINE_WORDS+1,
//     bready at LINE_WORDS+2 (bvalid same cycle), write_done at LINE_WORDS+3 (cycle 11 at default).
//   Beat counter is $clog2(LINE_WORDS) bits; no wrap past LINE_WORDS-1.
//   Reset: state=IDLE, beat=0.
//     - awvalid, wvalid, wlast, bready, write_done, write_err = 0.
//     - awaddr, wdata = 0; awlen/awsize/awburst/wstrb = their constants.
//   Reset mid-burst aborts silently: no write_done; the interconnect is reset alongside.
// TESTING
//   1 Always-ready slave, req_addr=0x1000_0047, word i=0xA0+i:
//       -> awaddr=0x1000_0040, awlen=7, awsize=3, awburst=1.
//       -> 8 beats 0xA0..0xA7, wlast only on 0xA7, write_done at cycle 11, write_err=0.
//   2 awready delayed 3 cycles, wready toggling 1/0:
//       -> AW fields and wdata/wlast stable while stalled, exactly 8 handshakes, in order.
//   3 bvalid delayed 5 cycles then bresp=2'b10:
//       -> bready held high, write_done=1 with write_err=1, req_ready=1 on the same cycle.
//   4 req_valid held high through the burst with a second line:
//       -> ignored until IDLE, then accepted in the write_done cycle.
//       -> second awvalid follows one cycle later.
//   5 reset asserted in DATA after beat 3:
//       -> next cycle wvalid=0, awvalid=0, bready=0, write_done=0, req_ready=0.
//       -> req_ready=1 on the first cycle with reset low.

Source files
------------

// File: rtl/dcache_line_writer.sv
// AXI4 write-channel initiator: takes one cache line from the memory stage and
// emits it as a single INCR burst on AW/W, then reports the B response.
module dcache_line_writer #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_line,
    output logic                             write_done,
    output logic                             write_err,
    output logic                             m_axi_awvalid,
    input  logic                             m_axi_awready,
    output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
    output logic [7:0]                       m_axi_awlen,
    output logic [2:0]                       m_axi_awsize,
    output logic [1:0]                       m_axi_awburst,
    output logic                             m_axi_wvalid,
    input  logic                             m_axi_wready,
    output logic [DATA_WIDTH-1:0]            m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]          m_axi_wstrb,
    output logic                             m_axi_wlast,
    input  logic                             m_axi_bvalid,
    output logic                             m_axi_bready,
    input  logic [1:0]                       m_axi_bresp
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int LINE_BYTES = LINE_WORDS * BEAT_BYTES;
    localparam int BEAT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_e;

    state_e                           state_q, state_d;
    logic [BEAT_W-1:0]                beat_q, beat_d;
    logic [LINE_WORDS*DATA_WIDTH-1:0] line_q, line_d;
    logic [ADDR_WIDTH-1:0]            awaddr_q, awaddr_d;
    logic                             done_q, done_d;
    logic                             err_q, err_d;

    // Only bresp[1] distinguishes error from success; bresp[0] is don't-care.
    logic unused_bresp0;
    assign unused_bresp0 = m_axi_bresp[0];

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        line_d   = line_q;
        awaddr_d = awaddr_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    line_d   = req_line;
                    awaddr_d = req_addr & ~LINE_MASK;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (m_axi_awready) begin
                    beat_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (m_axi_wready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (m_axi_bvalid) begin
                    done_d  = 1'b1;
                    err_d   = m_axi_bresp[1];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the line buffer is reset too because wdata is read straight out of
    // it and must be zero after reset; a pure data store would normally skip this.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            line_q   <= '0;
            awaddr_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            beat_q   <= beat_d;
            line_q   <= line_d;
            awaddr_q <= awaddr_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign write_done = done_q;
    assign write_err  = err_q;

    assign m_axi_awvalid = (state_q == S_ADDR);
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = 8'(LINE_WORDS - 1);
    assign m_axi_awsize  = 3'($clog2(BEAT_BYTES));
    assign m_axi_awburst = 2'b01;

    assign m_axi_wvalid = (state_q == S_DATA);
    assign m_axi_wdata  = line_q[beat_q*DATA_WIDTH +: DATA_WIDTH];
    assign m_axi_wstrb  = '1;
    assign m_axi_wlast  = (state_q == S_DATA) && (beat_q == LAST_BEAT);

    assign m_axi_bready = (state_q == S_RESP);

endmodule
